// File: rtl/alu_rs_scheduler_pkg.sv
// Shared types and readiness rule for the ALU reservation station.
package alu_rs_scheduler_pkg;

    localparam int unsigned RS_ALU_DEPTH = 8;
    localparam int unsigned PREG_W       = 6;
    localparam int unsigned ROB_TAG_W    = 6;
    localparam int unsigned ENTRY_W      = 96;

    // One ALU instruction as held in the reservation station (96 bits).
    typedef struct packed {
        logic [31:0]           pc;
        logic [31:0]           imm;
        logic [ROB_TAG_W-1:0]  rob_tag;
        logic [PREG_W-1:0]     p_dst;
        logic [PREG_W-1:0]     p_src1;
        logic [PREG_W-1:0]     p_src2;
        logic [3:0]            alu_op;
        logic                  alu_src;
        logic                  src1_ready;
        logic                  src2_ready;
        logic                  rd_we;
    } rs_entry_t;

    // Both operands available: stored ready bit, x0 mapping, or immediate for src2.
    function automatic logic src_eff_ready(input rs_entry_t e);
        logic s1;
        logic s2;
        s1 = e.src1_ready | (e.p_src1 == '0);
        s2 = e.src2_ready | (e.p_src2 == '0) | e.alu_src;
        return s1 & s2;
    endfunction

endpackage

// File: rtl/alu_rs_scheduler_age_matrix_picker.sv
// Age matrix tracking slot allocation order; grants the oldest eligible slot.
module age_matrix_picker #(
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [DEPTH-1:0] alloc,
    input  logic [DEPTH-1:0] free,
    input  logic [DEPTH-1:0] eligible,
    output logic [DEPTH-1:0] grant_c,
    output logic             grant_valid_c
);

    // age_q[i][j] = 1 means slot i was allocated before slot j.
    logic [DEPTH-1:0] age_q [DEPTH];
    logic [DEPTH-1:0] age_d [DEPTH];
    logic [DEPTH-1:0] blocked;

    // A slot wins when no older slot is also eligible.
    always_comb begin
        blocked = '0;
        grant_c = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            for (int unsigned j = 0; j < DEPTH; j++) begin
                if (eligible[j] && age_q[j][i]) begin
                    blocked[i] = 1'b1;
                end
            end
            grant_c[i] = eligible[i] & ~blocked[i];
        end
    end

    assign grant_valid_c = |grant_c;

    // Freed slots drop out of the order; a new slot is younger than every live slot.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            age_d[i] = age_q[i];
        end
        if (flush) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                age_d[i] = '0;
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                for (int unsigned j = 0; j < DEPTH; j++) begin
                    if (free[i] || free[j]) begin
                        age_d[i][j] = 1'b0;
                    end
                    if (alloc[j]) begin
                        age_d[i][j] = (i != j) && !free[i];
                    end
                    if (alloc[i]) begin
                        age_d[i][j] = 1'b0;
                    end
                end
            end
        end
    end

    // Age matrix register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                age_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                age_q[i] <= age_d[i];
            end
        end
    end

endmodule

// File: rtl/alu_rs_scheduler.sv
// ALU reservation station: holds dispatched ops, wakes them from the CDB,
// and issues the oldest ready op through a registered valid/ready stage.
module alu_rs_scheduler
    import alu_rs_scheduler_pkg::*;
#(
    parameter int unsigned DEPTH  = RS_ALU_DEPTH,
    parameter int unsigned PREG_W = 6
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         disp_valid,
    output logic                         disp_ready,
    input  logic [95:0]                  disp_entry,
    input  logic                         cdb_valid,
    input  logic [PREG_W-1:0]            cdb_tag,
    output logic                         iss_valid,
    input  logic                         iss_ready,
    output logic [95:0]                  iss_entry,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    rs_entry_t          slot_q [DEPTH];
    rs_entry_t          slot_d [DEPTH];
    logic [DEPTH-1:0]   valid_q;
    logic [DEPTH-1:0]   valid_d;
    logic [OCC_W-1:0]   occupancy_q;
    logic [OCC_W-1:0]   occ_d;
    logic               iss_valid_q;
    logic               iss_valid_d;
    rs_entry_t          iss_entry_q;
    rs_entry_t          iss_entry_d;

    logic [DEPTH-1:0]   eligible;
    logic [DEPTH-1:0]   alloc_oh;
    logic [DEPTH-1:0]   free_oh;
    logic [DEPTH-1:0]   grant_c;
    logic               grant_valid_c;
    logic               lowest_found;
    logic               disp_fire;
    logic               iss_fire;
    logic               out_free;
    rs_entry_t          din;
    rs_entry_t          pick;
    logic               rob_dup_c;

    assign disp_ready = (occupancy_q != OCC_W'(DEPTH));
    assign iss_valid  = iss_valid_q;
    assign iss_entry  = iss_entry_q;
    assign occupancy  = occupancy_q;

    // Slot eligibility from registered state only.
    always_comb begin
        eligible = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            eligible[i] = valid_q[i] & src_eff_ready(slot_q[i]);
        end
    end

    age_matrix_picker #(
        .DEPTH (DEPTH)
    ) u_picker (
        .clk           (clk),
        .rst           (reset),
        .flush         (flush),
        .alloc         (alloc_oh),
        .free          (free_oh),
        .eligible      (eligible),
        .grant_c       (grant_c),
        .grant_valid_c (grant_valid_c)
    );

    // Handshakes, lowest free slot, granted entry mux and dispatch-time bypass.
    always_comb begin
        alloc_oh     = '0;
        lowest_found = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!lowest_found && !valid_q[i]) begin
                alloc_oh[i]  = 1'b1;
                lowest_found = 1'b1;
            end
        end
        disp_fire = disp_valid && disp_ready && !flush;
        if (!disp_fire) begin
            alloc_oh = '0;
        end
        out_free = !iss_valid_q || iss_ready;
        iss_fire = grant_valid_c && out_free && !flush;
        free_oh  = iss_fire ? grant_c : '0;

        pick = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (grant_c[i]) begin
                pick = rs_entry_t'(pick | slot_q[i]);
            end
        end

        din = rs_entry_t'(disp_entry);
        if (cdb_valid && (cdb_tag == PREG_W'(din.p_src1))) begin
            din.src1_ready = 1'b1;
        end
        if (cdb_valid && (cdb_tag == PREG_W'(din.p_src2))) begin
            din.src2_ready = 1'b1;
        end
    end

    // Next state for slots, output stage and occupancy; flush overrides all.
    always_comb begin
        slot_d      = slot_q;
        valid_d     = valid_q;
        occ_d       = occupancy_q;
        iss_valid_d = iss_valid_q;
        iss_entry_d = iss_entry_q;
        if (flush) begin
            valid_d     = '0;
            occ_d       = '0;
            iss_valid_d = 1'b0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (valid_q[i] && cdb_valid && (cdb_tag == PREG_W'(slot_q[i].p_src1))) begin
                    slot_d[i].src1_ready = 1'b1;
                end
                if (valid_q[i] && cdb_valid && (cdb_tag == PREG_W'(slot_q[i].p_src2))) begin
                    slot_d[i].src2_ready = 1'b1;
                end
                if (free_oh[i]) begin
                    valid_d[i] = 1'b0;
                end
                if (alloc_oh[i]) begin
                    valid_d[i] = 1'b1;
                    slot_d[i]  = din;
                end
            end
            if (out_free) begin
                iss_valid_d = iss_fire;
                if (iss_fire) begin
                    iss_entry_d            = pick;
                    iss_entry_d.src1_ready = 1'b1;
                    iss_entry_d.src2_ready = 1'b1;
                end
            end
            occ_d = occupancy_q + OCC_W'(disp_fire) - OCC_W'(iss_fire);
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                slot_q[i] <= '0;
            end
            valid_q     <= '0;
            occupancy_q <= '0;
            iss_valid_q <= 1'b0;
            iss_entry_q <= '0;
        end else begin
            slot_q      <= slot_d;
            valid_q     <= valid_d;
            occupancy_q <= occ_d;
            iss_valid_q <= iss_valid_d;
            iss_entry_q <= iss_entry_d;
        end
    end

    // Detects two live slots carrying the same ROB tag.
    always_comb begin
        rob_dup_c = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            for (int unsigned j = i + 1; j < DEPTH; j++) begin
                if (valid_q[i] && valid_q[j] && (slot_q[i].rob_tag == slot_q[j].rob_tag)) begin
                    rob_dup_c = 1'b1;
                end
            end
        end
    end

    a_stall_stable: assert property (@(posedge clk) disable iff (reset)
        (iss_valid_q && !iss_ready) |=> $stable(iss_entry_q));
    a_rob_unique: assert property (@(posedge clk) disable iff (reset) !rob_dup_c);
    a_occ_bound: assert property (@(posedge clk) disable iff (reset)
        occupancy_q <= OCC_W'(DEPTH));

endmodule

// File: doc/alu_rs_scheduler.md
Name: alu_rs_scheduler

Overview:
Reservation-station scheduler for the ALU pipe. It sits between dispatch and the ALU functional unit and holds up to DEPTH rs_entry_t instructions. It wakes sources up from CDB broadcasts, selects the oldest entry with all operands ready, and issues that entry through a registered valid/ready output stage. It frees slots on issue and clears everything on a branch flush.

Parameters:
DEPTH, 8, number of RS slots (2..16)
PREG_W, 6, physical tag width; must match p_src/p_dst fields of rs_entry_t

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-high; clears all state
flush  in  1  mispredict flush; discards all held entries and pending issue
disp_valid  in  1  dispatch offers disp_entry
disp_ready  out  1  at least one free slot
disp_entry  in  96  rs_entry_t from dispatch (src1_ready/src2_ready reflect rename-time readiness)
cdb_valid  in  1  result broadcast valid
cdb_tag  in  PREG_W  physical tag being written back
iss_valid  out  1  iss_entry holds an instruction for the ALU
iss_ready  in  1  ALU accepts iss_entry
iss_entry  out  96  rs_entry_t issued, both ready bits set
occupancy  out  $clog2(DEPTH+1)  occupied slot count, excluding the output register

Behaviour:
- Reset (async): all slot valid bits = 0, age matrix = 0, iss_valid = 0, iss_entry = 0, occupancy = 0, disp_ready = 1.
- disp_ready = (occupancy != DEPTH), combinational from registered state only. A slot freed by issue this cycle does not raise disp_ready until the next cycle.
- Dispatch handshake: disp_valid & disp_ready at an edge writes disp_entry into the lowest-index free slot, which becomes the youngest entry in the age matrix.
- Effective source readiness:
  - srcN is ready if its stored ready bit = 1, or p_srcN == 0 (x0 mapping).
  - src2 is also ready if alu_src = 1 (immediate operand).
- Wakeup: cdb_valid with cdb_tag == p_srcN sets srcN_ready in every valid slot.
  - Applies to an entry being dispatched in the same cycle: the bypass is ORed into the written bits.
- Select:
  - Eligible = slot valid and both sources effectively ready, using registered bits only. A CDB wakeup at edge E makes an entry eligible in the cycle after E.
  - Pick = oldest eligible slot per the age matrix.
  - Out-stage free = !iss_valid | iss_ready.
  - If pick exists and out-stage free: at the edge, copy the entry into iss_entry with src1_ready = src2_ready = 1, set iss_valid = 1, free the slot, update the age matrix.
  - If out-stage not free: hold iss_valid and iss_entry stable (no change while stalled).
- Latency: dispatch of a fully ready entry at edge E0 → iss_valid at E1 (1 cycle). Back-to-back issue of 1 entry per cycle when iss_ready stays high.
- Occupancy: next = occupancy + dispatch − issue; dispatch and issue in the same cycle leaves it unchanged.
- Flush (synchronous, highest priority):
  - At the edge, clears all slots and the age matrix; iss_valid = 0, occupancy = 0.
  - Dispatch, issue and wakeup in that cycle are ignored.
  - iss_ready in a flush cycle has no effect: the entry is dropped, and the ALU must also squash it.
- Full: disp_valid with occupancy = DEPTH holds the entry at dispatch (disp_ready = 0). No overwrite.
- Empty: iss_valid drops after the last held entry drains.
- Reset mid-operation: immediate clear regardless of the handshake state.
- Assertions:
  - iss_valid & !iss_ready ⇒ iss_entry stable on the next edge.
  - No two valid slots share the same rob_tag.
  - occupancy ≤ DEPTH.

Decomposition:
- Shared package:
  - rs_entry_t (existing)
  - constants RS_ALU_DEPTH = 8, PREG_W = 6
  - function src_eff_ready(entry), so dispatch and the RS use identical readiness rules
- Sub-module age_matrix_picker (DEPTH×DEPTH age bits):
  - inputs: alloc one-hot, free one-hot, eligible vector
  - output: one-hot oldest-eligible grant plus a grant-valid bit
  - keeps the scheduler slot/wakeup logic separate from the ordering logic

Test Plan:
1. Reset, then dispatch pc=0x100 with src1_ready=1, alu_src=1 → iss_valid=1 one cycle later, iss_entry.pc=0x100, occupancy returns to 0.
2. Dispatch A(p_src1=12, not ready) then B(ready); cdb_valid, cdb_tag=12 two cycles later → B issues first, A issues the cycle after the wakeup edge + 1, both with ready bits = 1.
3. Dispatch a not-ready entry with p_src1=20 in the same cycle as cdb_tag=20 → entry stored ready and issued next cycle (same-cycle bypass).
4. Fill 8 not-ready entries → disp_ready=0, occupancy=8; a 9th disp_valid is held. One CDB wakeup frees a slot → disp_ready=1 one cycle after the issue.
5. Three ready entries dispatched in order C, D, E with iss_ready=0 for 3 cycles → iss_entry stays C throughout. Release iss_ready → C, D, E issue in consecutive cycles (oldest-first).
6. Five entries held and iss_valid=1; assert flush together with disp_valid and iss_ready → next cycle occupancy=0, iss_valid=0, dispatched entry not present, disp_ready=1.
